// File: rtl/gf180mcu_ocd_io_pkg.sv
// Shared definitions for the gf180mcu bi_t pad controller: FSM states,
// counter width helper and static pad-strap defaults.
package gf180mcu_ocd_io_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TX,
        ST_TURN,
        ST_WAIT_START,
        ST_RX,
        ST_DONE
    } state_e;

    localparam logic [1:0] DEF_DRIVE   = 2'b10;
    localparam logic       DEF_SLEW    = 1'b0;
    localparam logic       DEF_SCHMITT = 1'b1;

    // Width of a counter that must hold values 0..n-1.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/gf180mcu_ocd_io_sync2.sv
// Two-flop synchroniser for the pad Y input; resets to the idle-high bus level.
module gf180mcu_ocd_io_sync2 (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/gf180mcu_ocd_io_bi_t_ctrl.sv
// Half-duplex single-wire transceiver driving one bi_t pad cell.
// Optional even-parity bit in both directions under `BI_T_CTRL_PARITY_EN.
module gf180mcu_ocd_io_bi_t_ctrl
    import gf180mcu_ocd_io_pkg::*;
#(
    parameter int unsigned DW          = 8,
    parameter int unsigned BIT_DIV     = 16,
    parameter int unsigned TURN_CYC    = 4,
    parameter int unsigned TIMEOUT_CYC = 1024,
    parameter logic [1:0]  DRIVE       = DEF_DRIVE,
    parameter logic        SLEW        = DEF_SLEW,
    parameter logic        SCHMITT     = DEF_SCHMITT
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          TX_VALID,
    output logic          TX_READY,
    input  logic [DW-1:0] TX_DATA,
    output logic          RX_VALID,
    input  logic          RX_READY,
    output logic [DW-1:0] RX_DATA,
    output logic          RX_TOUT,
    output logic          RX_PERR,
    output logic          PAD_A,
    output logic          PAD_OE,
    output logic          PAD_IE,
    output logic          PAD_PU,
    output logic          PAD_PD,
    output logic          PAD_PDRV0,
    output logic          PAD_PDRV1,
    output logic          PAD_SL,
    output logic          PAD_CS,
    input  logic          PAD_Y
);

`ifdef BI_T_CTRL_PARITY_EN
    localparam int unsigned PAR_BITS = 1;
`else
    localparam int unsigned PAR_BITS = 0;
`endif
    // TX frame: start, data, [parity], stop. RX sample points: start, data, [parity].
    localparam int unsigned NTX   = DW + PAR_BITS + 2;
    localparam int unsigned NRX   = DW + PAR_BITS + 1;
    localparam int unsigned DIV_W = cnt_w(BIT_DIV);
    localparam int unsigned IDX_W = cnt_w(NTX);
    localparam int unsigned CNT_W = cnt_w(max2(TURN_CYC, TIMEOUT_CYC));

    state_e           state_q;
    logic             tx_ready_q;
    logic             rx_valid_q;
    logic [DW-1:0]    rx_data_q;
    logic             rx_tout_q;
    logic             rx_perr_q;
    logic             oe_q;
    logic             a_q;
    logic             ie_q;
    logic [DW-1:0]    tx_sh_q;
    logic [DW-1:0]    rx_sh_q;
    logic [DIV_W-1:0] div_q;
    logic [IDX_W-1:0] idx_q;
    logic [CNT_W-1:0] cnt_q;
`ifdef BI_T_CTRL_PARITY_EN
    logic             tx_par_q;
`endif

    logic             ys;
    logic [DW-1:0]    rx_word_d;
    logic             div_last;

    gf180mcu_ocd_io_sync2 u_sync (
        .clk_i (CLK),
        .rst_i (RST),
        .d_i   (PAD_Y),
        .q_o   (ys)
    );

    always_comb begin
        rx_word_d = {rx_sh_q[DW-2:0], ys};
        div_last  = (div_q == DIV_W'(BIT_DIV - 1));
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            tx_ready_q <= 1'b1;
            rx_valid_q <= 1'b0;
            rx_data_q  <= '0;
            rx_tout_q  <= 1'b0;
            rx_perr_q  <= 1'b0;
            oe_q       <= 1'b0;
            a_q        <= 1'b1;
            ie_q       <= 1'b0;
            tx_sh_q    <= '0;
            rx_sh_q    <= '0;
            div_q      <= '0;
            idx_q      <= '0;
            cnt_q      <= '0;
`ifdef BI_T_CTRL_PARITY_EN
            tx_par_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (TX_VALID) begin
                        tx_sh_q    <= TX_DATA;
`ifdef BI_T_CTRL_PARITY_EN
                        tx_par_q   <= ^TX_DATA;
`endif
                        state_q    <= ST_TX;
                        tx_ready_q <= 1'b0;
                        oe_q       <= 1'b1;
                        a_q        <= 1'b0;
                        div_q      <= '0;
                        idx_q      <= '0;
                    end
                end

                ST_TX: begin
                    if (div_last) begin
                        div_q <= '0;
                        if (idx_q == IDX_W'(NTX - 1)) begin
                            state_q <= ST_TURN;
                            oe_q    <= 1'b0;
                            a_q     <= 1'b1;
                            cnt_q   <= '0;
                        end else begin
                            // idx_q is the bit just finished; load the next one
                            idx_q <= idx_q + 1'b1;
                            if (idx_q < IDX_W'(DW)) begin
                                a_q     <= tx_sh_q[DW-1];
                                tx_sh_q <= {tx_sh_q[DW-2:0], 1'b0};
`ifdef BI_T_CTRL_PARITY_EN
                            end else if (idx_q == IDX_W'(DW)) begin
                                a_q <= tx_par_q;
`endif
                            end else begin
                                a_q <= 1'b1;
                            end
                        end
                    end else begin
                        div_q <= div_q + 1'b1;
                    end
                end

                ST_TURN: begin
                    if (cnt_q == CNT_W'(TURN_CYC - 1)) begin
                        state_q <= ST_WAIT_START;
                        ie_q    <= 1'b1;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                ST_WAIT_START: begin
                    if (!ys) begin
                        state_q <= ST_RX;
                        div_q   <= DIV_W'(BIT_DIV / 2);
                        idx_q   <= '0;
                    end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                        state_q    <= ST_DONE;
                        rx_valid_q <= 1'b1;
                        rx_tout_q  <= 1'b1;
                        rx_perr_q  <= 1'b0;
                        rx_data_q  <= '0;
                        ie_q       <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                ST_RX: begin
                    if (div_last) begin
                        div_q <= '0;
                        if (idx_q == IDX_W'(NRX - 1)) begin
                            state_q    <= ST_DONE;
                            rx_valid_q <= 1'b1;
                            rx_tout_q  <= 1'b0;
                            ie_q       <= 1'b0;
`ifdef BI_T_CTRL_PARITY_EN
                            rx_data_q  <= rx_sh_q;
                            rx_perr_q  <= (^rx_sh_q) ^ ys;
`else
                            rx_data_q  <= rx_word_d;
                            rx_perr_q  <= 1'b0;
`endif
                        end else begin
                            idx_q <= idx_q + 1'b1;
                            // sample point 0 is mid-start-bit, nothing to shift
                            if (idx_q != '0) begin
                                rx_sh_q <= rx_word_d;
                            end
                        end
                    end else begin
                        div_q <= div_q + 1'b1;
                    end
                end

                ST_DONE: begin
                    if (RX_READY) begin
                        state_q    <= ST_IDLE;
                        rx_valid_q <= 1'b0;
                        tx_ready_q <= 1'b1;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign TX_READY  = tx_ready_q;
    assign RX_VALID  = rx_valid_q;
    assign RX_DATA   = rx_data_q;
    assign RX_TOUT   = rx_tout_q;
    assign RX_PERR   = rx_perr_q;
    assign PAD_A     = a_q;
    assign PAD_OE    = oe_q;
    assign PAD_IE    = ie_q;
    assign PAD_PU    = 1'b1;
    assign PAD_PD    = 1'b0;
    assign PAD_PDRV0 = DRIVE[0];
    assign PAD_PDRV1 = DRIVE[1];
    assign PAD_SL    = SLEW;
    assign PAD_CS    = SCHMITT;

endmodule

// File: tb/tb_gf180mcu_ocd_io_bi_t_ctrl.sv
// Directed self-checking bench for gf180mcu_ocd_io_bi_t_ctrl (DW=8, BIT_DIV=16).
module tb_gf180mcu_ocd_io_bi_t_ctrl;

    localparam int unsigned DW  = 8;
    localparam int unsigned BD  = 16;
    localparam int unsigned TC  = 4;
    localparam int unsigned TO  = 1024;
`ifdef BI_T_CTRL_PARITY_EN
    localparam int unsigned NB  = 11;
    localparam bit          PAR = 1'b1;
`else
    localparam int unsigned NB  = 10;
    localparam bit          PAR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          tx_valid = 1'b0;
    logic          tx_ready;
    logic [DW-1:0] tx_data = '0;
    logic          rx_valid;
    logic          rx_ready = 1'b0;
    logic [DW-1:0] rx_data;
    logic          rx_tout, rx_perr;
    logic          pad_a, pad_oe, pad_ie, pad_pu, pad_pd;
    logic          pad_pdrv0, pad_pdrv1, pad_sl, pad_cs;
    logic          pad_y;
    logic          resp = 1'b1;
    logic [DW-1:0] resp_word = '0;
    logic          resp_par = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;
    int oe_rises = 0;
    logic oe_prev = 1'b0;

    // Loopback while driving, otherwise responder / pull-up.
    assign pad_y = pad_oe ? pad_a : resp;

    always #5 clk = ~clk;

    gf180mcu_ocd_io_bi_t_ctrl #(
        .DW(DW), .BIT_DIV(BD), .TURN_CYC(TC), .TIMEOUT_CYC(TO),
        .DRIVE(2'b10), .SLEW(1'b0), .SCHMITT(1'b1)
    ) dut (
        .CLK(clk), .RST(rst),
        .TX_VALID(tx_valid), .TX_READY(tx_ready), .TX_DATA(tx_data),
        .RX_VALID(rx_valid), .RX_READY(rx_ready), .RX_DATA(rx_data),
        .RX_TOUT(rx_tout), .RX_PERR(rx_perr),
        .PAD_A(pad_a), .PAD_OE(pad_oe), .PAD_IE(pad_ie),
        .PAD_PU(pad_pu), .PAD_PD(pad_pd),
        .PAD_PDRV0(pad_pdrv0), .PAD_PDRV1(pad_pdrv1),
        .PAD_SL(pad_sl), .PAD_CS(pad_cs), .PAD_Y(pad_y)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("oe_ie_exclusive", {31'b0, pad_oe & pad_ie}, 32'd0);
        if (pad_oe && !oe_prev) oe_rises++;
        oe_prev <= pad_oe;
    end

    task automatic drive_frame();
        resp = 1'b0;
        repeat (BD) @(negedge clk);
        for (int i = DW - 1; i >= 0; i--) begin
            resp = resp_word[i];
            repeat (BD) @(negedge clk);
        end
        if (PAR) begin
            resp = resp_par;
            repeat (BD) @(negedge clk);
        end
        resp = 1'b1;
    endtask

    task automatic run_txn(input logic [DW-1:0] txd, input logic [DW-1:0] rsd,
                           input logic rsp, input logic exp_perr);
        logic [10:0]   eb;
        logic [DW-1:0] held;
        int            n;
        eb    = '0;
        eb[0] = 1'b0;
        for (int i = 0; i < int'(DW); i++) eb[1 + i] = txd[DW - 1 - i];
        if (PAR) eb[DW + 1] = ^txd;
        eb[NB - 1] = 1'b1;

        @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = txd;
        @(negedge clk);
        tx_valid = 1'b0;
        check("tx_ready_busy", {31'b0, tx_ready}, 32'd0);
        for (int b = 0; b < int'(NB); b++) begin
            for (int c = 0; c < int'(BD); c++) begin
                check($sformatf("tx_a_bit%0d", b), {31'b0, pad_a}, {31'b0, eb[b]});
                check("tx_oe", {31'b0, pad_oe}, 32'd1);
                @(negedge clk);
            end
        end
        for (int c = 0; c < int'(TC); c++) begin
            check("turn_oe_ie_a", {29'b0, pad_oe, pad_ie, pad_a}, 32'b001);
            @(negedge clk);
        end
        check("ie_after_turn", {31'b0, pad_ie}, 32'd1);

        repeat (BD) @(negedge clk);
        resp_word = rsd;
        resp_par  = rsp;
        fork
            drive_frame();
        join_none

        n = 0;
        while (!rx_valid && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("rx_valid_seen", {31'b0, rx_valid}, 32'd1);
        check("rx_data", {24'b0, rx_data}, {24'b0, rsd});
        check("rx_tout", {31'b0, rx_tout}, 32'd0);
        check("rx_perr", {31'b0, rx_perr}, {31'b0, exp_perr});
        check("ie_in_done", {31'b0, pad_ie}, 32'd0);
        held = rx_data;
        repeat (5) begin
            @(negedge clk);
            check("rx_valid_held", {31'b0, rx_valid}, 32'd1);
            check("rx_data_held", {24'b0, rx_data}, {24'b0, held});
        end
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        check("rx_valid_cleared", {31'b0, rx_valid}, 32'd0);
        check("tx_ready_back", {31'b0, tx_ready}, 32'd1);
        repeat (40) @(negedge clk);
    endtask

    initial begin
        int n;
        int seen_rxv;
        int seen_oe;

        repeat (3) @(negedge clk);
        check("rst_tx_ready", {31'b0, tx_ready}, 32'd1);
        check("rst_rx_valid", {31'b0, rx_valid}, 32'd0);
        check("rst_rx_data", {24'b0, rx_data}, 32'd0);
        check("rst_flags", {30'b0, rx_tout, rx_perr}, 32'd0);
        check("rst_oe_a_ie", {29'b0, pad_oe, pad_a, pad_ie}, 32'b010);
        check("rst_pu_pd", {30'b0, pad_pu, pad_pd}, 32'b10);
        check("rst_statics", {28'b0, pad_pdrv1, pad_pdrv0, pad_sl, pad_cs}, 32'b1001);
        rst = 1'b0;
        @(negedge clk);
        check("statics_run", {28'b0, pad_pdrv1, pad_pdrv0, pad_sl, pad_cs}, 32'b1001);

        // A5: 4 ones -> parity 0; 3C: 4 ones -> parity 0.
        run_txn(8'hA5, 8'h3C, 1'b0, 1'b0);
        // 01 -> parity 1; response 03 with parity 1 is odd overall.
        run_txn(8'h01, 8'h03, 1'b1, PAR);

        // Timeout with RX_READY already high, plus a TX_VALID pulse while busy.
        rx_ready = 1'b1;
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = 8'h5A;
        @(negedge clk);
        tx_valid = 1'b0;
        repeat (20) @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = 8'hFF;
        @(negedge clk);
        tx_valid = 1'b0;
        n = 0;
        while (!pad_ie && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("tout_ie_seen", {31'b0, pad_ie}, 32'd1);
        n = 0;
        while (!rx_valid && n < TO + 100) begin
            @(negedge clk);
            n++;
        end
        check("tout_latency", n, TO);
        check("tout_flag", {31'b0, rx_tout}, 32'd1);
        check("tout_data", {24'b0, rx_data}, 32'd0);
        check("tout_perr", {31'b0, rx_perr}, 32'd0);
        check("tout_ie", {31'b0, pad_ie}, 32'd0);
        @(negedge clk);
        check("tout_valid_pulse", {31'b0, rx_valid}, 32'd0);
        check("tout_tx_ready", {31'b0, tx_ready}, 32'd1);
        rx_ready = 1'b0;
        repeat (5) @(negedge clk);

        // Reset during data bit 3.
        tx_valid = 1'b1;
        tx_data  = 8'hC3;
        @(negedge clk);
        tx_valid = 1'b0;
        repeat (3 * BD + 4) @(negedge clk);
        check("midtx_oe", {31'b0, pad_oe}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_oe_a", {30'b0, pad_oe, pad_a}, 32'b01);
        check("abort_tx_ready", {31'b0, tx_ready}, 32'd1);
        check("abort_ie", {31'b0, pad_ie}, 32'd0);
        seen_rxv = 0;
        seen_oe  = 0;
        repeat (TO + 200) begin
            @(negedge clk);
            if (rx_valid) seen_rxv = 1;
            if (pad_oe) seen_oe = 1;
        end
        check("no_rx_valid_after_rst", seen_rxv, 0);
        check("no_oe_after_rst", seen_oe, 0);
        check("transfer_count", oe_rises, 4);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
